// File: rtl/dac_spi_tx_if.sv
// dac_spi_tx_if: code strobe from the scan generator plus the SPI/LDAC pins and status of dac_spi_tx.
// master = generator/observer side, slave = the serialiser itself.
interface dac_spi_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              dac_sclk;
  logic              dac_sdi;
  logic              dac_cs_n;
  logic              dac_ldac_n;
  logic              busy;
  logic              frame_done;
  logic              drop_pulse;

  modport master (
    output din, din_valid,
    input  dac_sclk, dac_sdi, dac_cs_n, dac_ldac_n, busy, frame_done, drop_pulse
  );

  modport slave (
    input  din, din_valid,
    output dac_sclk, dac_sdi, dac_cs_n, dac_ldac_n, busy, frame_done, drop_pulse
  );
endinterface

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises scan-generator codes MSB-first to an SPI DAC (CPOL=0, CPHA=0), then pulses LDAC_n.
// Defining DAC_OVF_CNT_EN adds the saturating ovf_cnt port counting overwritten pending codes.
module dac_spi_tx #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  dac_spi_tx_if.slave bus
`ifdef DAC_OVF_CNT_EN
  ,
  output logic [15:0] ovf_cnt
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_LDAC
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic [DATA_W-2:0] r_shreg, w_shreg_nxt;
  logic              r_sclk, w_sclk_nxt;
  logic              r_sdi, w_sdi_nxt;
  logic              r_cs_n, w_cs_n_nxt;
  logic              r_ldac_n, w_ldac_n_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_frame_done, w_frame_done_nxt;
  logic              r_drop, w_drop_nxt;
  logic [DATA_W-1:0] r_pend, w_pend_nxt;
  logic              r_pend_vld, w_pend_vld_nxt;

  logic              w_tick;
  logic              w_load;
  logic              w_from_pend;
  logic [DATA_W-1:0] w_load_word;

  assign w_tick = (r_div == DIV_LAST);

  // r_shreg holds only the bits still to be presented; the MSB goes straight to dac_sdi at load.
  always_comb begin
    w_state_nxt      = r_state;
    w_div_nxt        = r_div + DIV_W'(1);
    w_bit_nxt        = r_bit;
    w_shreg_nxt      = r_shreg;
    w_sclk_nxt       = r_sclk;
    w_sdi_nxt        = r_sdi;
    w_cs_n_nxt       = r_cs_n;
    w_ldac_n_nxt     = r_ldac_n;
    w_frame_done_nxt = 1'b0;
    w_drop_nxt       = 1'b0;
    w_pend_nxt       = r_pend;
    w_pend_vld_nxt   = r_pend_vld;
    w_load           = 1'b0;
    w_from_pend      = 1'b0;
    w_load_word      = bus.din;

    if (r_state == S_IDLE || w_tick) w_div_nxt = '0;

    case (r_state)
      S_IDLE: begin
        if (bus.din_valid) w_load = 1'b1;
      end
      S_SETUP: begin
        if (w_tick) begin
          w_sclk_nxt  = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_tick) begin
          w_sclk_nxt = ~r_sclk;
          if (r_sclk) begin
            if (r_bit == BIT_LAST) begin
              w_state_nxt = S_CS_HOLD;
            end else begin
              w_bit_nxt   = r_bit + BIT_W'(1);
              w_sdi_nxt   = r_shreg[DATA_W-2];
              w_shreg_nxt = {r_shreg[DATA_W-3:0], 1'b0};
            end
          end
        end
      end
      S_CS_HOLD: begin
        if (w_tick) begin
          w_cs_n_nxt   = 1'b1;
          w_ldac_n_nxt = 1'b0;
          w_state_nxt  = S_LDAC;
        end
      end
      S_LDAC: begin
        if (w_tick) begin
          w_ldac_n_nxt     = 1'b1;
          w_frame_done_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
          if (r_pend_vld) begin
            w_load      = 1'b1;
            w_from_pend = 1'b1;
            w_load_word = r_pend;
          end else if (bus.din_valid) begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_shreg_nxt = w_load_word[DATA_W-2:0];
      w_sdi_nxt   = w_load_word[DATA_W-1];
      w_cs_n_nxt  = 1'b0;
      w_bit_nxt   = '0;
      w_state_nxt = S_SETUP;
    end

    // A strobe not consumed directly lands in the pending slot; a still-unsent occupant is lost.
    if (bus.din_valid && !(w_load && !w_from_pend)) begin
      w_pend_nxt     = bus.din;
      w_pend_vld_nxt = 1'b1;
      w_drop_nxt     = r_pend_vld && !w_from_pend;
    end else if (w_from_pend) begin
      w_pend_vld_nxt = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_bit        <= '0;
      r_shreg      <= '0;
      r_sclk       <= 1'b0;
      r_sdi        <= 1'b0;
      r_cs_n       <= 1'b1;
      r_ldac_n     <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_drop       <= 1'b0;
      r_pend       <= '0;
      r_pend_vld   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_bit        <= w_bit_nxt;
      r_shreg      <= w_shreg_nxt;
      r_sclk       <= w_sclk_nxt;
      r_sdi        <= w_sdi_nxt;
      r_cs_n       <= w_cs_n_nxt;
      r_ldac_n     <= w_ldac_n_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_drop       <= w_drop_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
    end
  end

  assign bus.dac_sclk   = r_sclk;
  assign bus.dac_sdi    = r_sdi;
  assign bus.dac_cs_n   = r_cs_n;
  assign bus.dac_ldac_n = r_ldac_n;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.drop_pulse = r_drop;

`ifdef DAC_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  // Counts on the same edge that raises drop_pulse, so both views agree cycle for cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (w_drop_nxt && r_ovf_cnt != 16'hFFFF) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: scoreboard bench for dac_spi_tx; a CLK_DIV=2 and a CLK_DIV=1 instance share clock and reset.
// Stimulus pushes expected words; a negedge monitor reassembles SPI frames, checks timing and pops/compares.
module tb_dac_spi_tx;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   expDrops = 0;
  int   expOvf = 0;

  logic [DW-1:0] expQ0[$];
  logic [DW-1:0] expQ1[$];

  int            startCyc[2];
  int            bitCnt[2];
  int            csHighCyc[2];
  int            ldacCyc[2];
  int            doneCyc[2];
  int            dropSeen[2];
  logic [DW-1:0] word[2];
  logic          prevSclk[2];
  logic          prevCs[2];
  logic          prevLdac[2];

  dac_spi_tx_if #(.DATA_W(DW)) if0 ();
  dac_spi_tx_if #(.DATA_W(DW)) if1 ();

`ifdef DAC_OVF_CNT_EN
  logic [15:0] ovf0;
  logic [15:0] ovf1;
`endif

  dac_spi_tx #(.DATA_W(DW), .CLK_DIV(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
`ifdef DAC_OVF_CNT_EN
    ,
    .ovf_cnt (ovf0)
`endif
  );

  dac_spi_tx #(.DATA_W(DW), .CLK_DIV(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
`ifdef DAC_OVF_CNT_EN
    ,
    .ovf_cnt (ovf1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic monStep(input int id, input int cd, input logic sclk, input logic sdi, input logic csN,
                         input logic ldacN, input logic done, input logic drop);
    logic [DW-1:0] expWord;
    bit            have;
    have    = 1'b0;
    expWord = '0;
    if (!rst_n) begin
      bitCnt[id]  = 0;
      doneCyc[id] = -100;
    end else begin
      if (sclk !== prevSclk[id]) checkOutput("sclk_moves_only_with_cs", csN, 1'b0);
      if (sclk && !prevSclk[id]) begin
        checkOutput("sclk_rise_time", cyc - startCyc[id], cd * (2 * bitCnt[id] + 1));
        word[id] = {word[id][DW-2:0], sdi};
        bitCnt[id]++;
      end
      if (csN && !prevCs[id]) begin
        checkOutput("cs_low_len", cyc - startCyc[id], cd * (2 * DW + 1));
        csHighCyc[id] = cyc;
      end
      if (!ldacN && prevLdac[id]) begin
        checkOutput("ldac_start", cyc - startCyc[id], cd * (2 * DW + 1));
        ldacCyc[id] = cyc;
      end
      if (ldacN && !prevLdac[id]) checkOutput("ldac_low_len", cyc - ldacCyc[id], cd);
      if (done) begin
        checkOutput("frame_len", cyc - startCyc[id], cd * (2 * DW + 2));
        checkOutput("bit_count", bitCnt[id], DW);
        if (id == 0 && expQ0.size() > 0) begin
          expWord = expQ0.pop_front();
          have    = 1'b1;
        end
        if (id == 1 && expQ1.size() > 0) begin
          expWord = expQ1.pop_front();
          have    = 1'b1;
        end
        if (have) begin
          checkOutput("frame_word", word[id], expWord);
        end else begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_frame: got word 0x%0h on dut%0d, required no frame", word[id], id);
        end
        doneCyc[id] = cyc;
      end
      if (!csN && prevCs[id]) begin
        if (doneCyc[id] == cyc) checkOutput("cs_gap", cyc - csHighCyc[id], cd);
        startCyc[id] = cyc;
        bitCnt[id]   = 0;
        word[id]     = '0;
      end
      if (drop) dropSeen[id]++;
    end
    prevSclk[id] = sclk;
    prevCs[id]   = csN;
    prevLdac[id] = ldacN;
  endtask

  always @(negedge clk) begin
    monStep(0, 2, if0.dac_sclk, if0.dac_sdi, if0.dac_cs_n, if0.dac_ldac_n, if0.frame_done, if0.drop_pulse);
    monStep(1, 1, if1.dac_sclk, if1.dac_sdi, if1.dac_cs_n, if1.dac_ldac_n, if1.frame_done, if1.drop_pulse);
  end

  // Drives a one-cycle strobe so that the DUT samples it at posedge number edgeCyc.
  task automatic applyStimulus(input int id, input logic [DW-1:0] code, input int edgeCyc, input bit sent);
    int guard;
    guard = 0;
    while (cyc < edgeCyc - 1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != edgeCyc - 1) begin
      checks++;
      failures++;
      $display("[TB] FAIL stim_timing: got cycle %0d, required %0d", cyc, edgeCyc - 1);
    end
    if (id == 0) begin
      if0.din       = code;
      if0.din_valid = 1'b1;
      if (sent) expQ0.push_back(code);
    end else begin
      if1.din       = code;
      if1.din_valid = 1'b1;
      if (sent) expQ1.push_back(code);
    end
    @(negedge clk);
    if0.din_valid = 1'b0;
    if1.din_valid = 1'b0;
  endtask

  task automatic waitCyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic waitIdle(input int id);
    int guard;
    guard = 0;
    @(negedge clk);
    while (((id == 0) ? if0.busy : if1.busy) !== 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout: got busy=1 after %0d cycles, required busy=0", guard);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_sclk"}, if0.dac_sclk, 1'b0);
    checkOutput({tag, "_sdi"}, if0.dac_sdi, 1'b0);
    checkOutput({tag, "_cs_n"}, if0.dac_cs_n, 1'b1);
    checkOutput({tag, "_ldac_n"}, if0.dac_ldac_n, 1'b1);
    checkOutput({tag, "_busy"}, if0.busy, 1'b0);
    checkOutput({tag, "_frame_done"}, if0.frame_done, 1'b0);
    checkOutput({tag, "_drop"}, if0.drop_pulse, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0;
    rst_n         = 1'b0;
    if0.din       = '0;
    if0.din_valid = 1'b0;
    if1.din       = '0;
    if1.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("reset_dut1_cs_n", if1.dac_cs_n, 1'b1);
    checkOutput("reset_dut1_busy", if1.busy, 1'b0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single word 0xA5C3, CLK_DIV=2");
    e0 = cyc + 2;
    applyStimulus(0, 16'hA5C3, e0, 1'b1);
    checkOutput("t1_cs_low_at_e0", if0.dac_cs_n, 1'b0);
    checkOutput("t1_sdi_msb_at_e0", if0.dac_sdi, 1'b1);
    checkOutput("t1_busy_at_e0", if0.busy, 1'b1);
    waitIdle(0);
    checkOutput("t1_all_sent", expQ0.size(), 0);

    $display("[TB] back-to-back 0x1234 then 0x5678");
    e0 = cyc + 2;
    applyStimulus(0, 16'h1234, e0, 1'b1);
    applyStimulus(0, 16'h5678, e0 + 10, 1'b1);
    waitIdle(0);
    checkOutput("t2_all_sent", expQ0.size(), 0);
    checkOutput("t2_drops", dropSeen[0], expDrops);

    $display("[TB] overwrite of pending word");
    e0 = cyc + 2;
    applyStimulus(0, 16'h0F0F, e0, 1'b1);
    applyStimulus(0, 16'h1111, e0 + 10, 1'b0);
    applyStimulus(0, 16'h2222, e0 + 20, 1'b0);
    applyStimulus(0, 16'h3333, e0 + 30, 1'b1);
    expDrops += 2;
    expOvf   += 2;
    waitIdle(0);
    checkOutput("t3_all_sent", expQ0.size(), 0);
    checkOutput("t3_drops", dropSeen[0], expDrops);
`ifdef DAC_OVF_CNT_EN
    checkOutput("t3_ovf_cnt", ovf0, expOvf);
`endif

    $display("[TB] pending and din_valid together at frame end");
    e0 = cyc + 2;
    applyStimulus(0, 16'hAAAA, e0, 1'b1);
    applyStimulus(0, 16'hBBBB, e0 + 10, 1'b1);
    applyStimulus(0, 16'hCCCC, e0 + 68, 1'b1);
    waitIdle(0);
    checkOutput("t6_all_sent", expQ0.size(), 0);
    checkOutput("t6_drops", dropSeen[0], expDrops);

    $display("[TB] reset in mid-frame");
    e0 = cyc + 2;
    applyStimulus(0, 16'h7E81, e0, 1'b1);
    applyStimulus(0, 16'h4444, e0 + 5, 1'b0);
    waitCyc(e0 + 27);
    #2 rst_n = 1'b0;
    #1 checkIdleOutputs("midreset");
    expQ0.delete();
    expOvf = 0;
    repeat (3) @(negedge clk);
`ifdef DAC_OVF_CNT_EN
    checkOutput("t4_ovf_cleared", ovf0, expOvf);
`endif
    #2 rst_n = 1'b1;
    @(negedge clk);
    e0 = cyc + 2;
    applyStimulus(0, 16'hFFFF, e0, 1'b1);
    checkOutput("t4_cs_low_after_reset", if0.dac_cs_n, 1'b0);
    waitIdle(0);
    checkOutput("t4_all_sent", expQ0.size(), 0);
    checkOutput("t4_drops", dropSeen[0], expDrops);

    $display("[TB] CLK_DIV=1 word 0x8001");
    e0 = cyc + 2;
    applyStimulus(1, 16'h8001, e0, 1'b1);
    checkOutput("t5_cs_low_at_e0", if1.dac_cs_n, 1'b0);
    checkOutput("t5_sdi_msb_at_e0", if1.dac_sdi, 1'b1);
    waitIdle(1);
    checkOutput("t5_all_sent", expQ1.size(), 0);
    checkOutput("t5_drops", dropSeen[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
